// File: rtl/alu_pipe_nzcv.sv
// -----------------------------------------------------------------------------
// alu_pipe_nzcv
//   Registered, width-parametrised ALU producing a result plus NZCV flags, with
//   valid/ready handshakes on the operand side and the result side. One output
//   register gives one-cycle latency and full throughput for the single-cycle
//   opcodes. An optional shift-add multiplier (opcode 111) is enabled by
//   defining the macro ALU_PIPE_MUL_EN. Without it, opcode 111 is an illegal
//   single-cycle op returning zero.
//
// Parameters
//   WIDTH       operand/result width in bits (>= 2)
//
// Ports
//   i_clk       clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_valid     operand bundle valid
//   o_ready     operands accepted this cycle when i_valid is also high
//   i_A, i_B    operands (two's complement for signed ops)
//   i_opcode    000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT,
//               110 SHL, 111 MUL (or illegal)
//   o_valid     o_result/o_status hold a result
//   i_ready     consumer takes the result this cycle
//   o_result    result
//   o_status    {N,Z,C,V}
//   o_busy      multiply in progress
// -----------------------------------------------------------------------------
module alu_pipe_nzcv #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   input  logic [2:0]       i_opcode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [3:0]       o_status,
   output logic             o_busy
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] res,
                                       input logic             c,
                                       input logic             v);
      return {res[WIDTH-1], (res == '0), c, v};
   endfunction

   // Single-cycle datapath: returns {status, result}.
   function automatic logic [WIDTH+3:0] alu_calc(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       op);
      logic [WIDTH:0]          ext;
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [WIDTH-1:0]        res;
      logic                    c;
      logic                    v;
      ext = '0;
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      sa  = signed'(a);
      sb  = signed'(b);
      case (op)
         OP_ADD: begin
            ext = {1'b0, a} + {1'b0, b};
            res = ext[WIDTH-1:0];
            c   = ext[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            ext = {1'b0, a} - {1'b0, b};
            res = ext[WIDTH-1:0];
            c   = ~ext[WIDTH];   // carry means "no borrow"
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SLT: res = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
         OP_SHL: begin
            res = {a[WIDTH-2:0], 1'b0};
            c   = a[WIDTH-1];
         end
         // Illegal op when the multiplier is absent; the multiplier bypasses this path.
         OP_MUL: res = '0;
      endcase
      return {nzcv(res, c, v), res};
   endfunction

   logic             r_vld_p1;
   logic [WIDTH-1:0] r_result_p1;
   logic [3:0]       r_status_p1;
   logic [WIDTH+3:0] w_alu;
   logic             w_accept;
   logic             w_accept_alu;
   logic             w_idle;

   assign w_alu    = alu_calc(i_A, i_B, i_opcode);
   assign w_accept = i_valid && o_ready;
   assign o_ready  = w_idle && (!r_vld_p1 || i_ready);

`ifdef ALU_PIPE_MUL_EN
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]     r_mplier;
   logic                 w_start_mul;
   logic                 w_mul_last;

   assign w_start_mul  = w_accept && (i_opcode == OP_MUL);
   assign w_accept_alu = w_accept && (i_opcode != OP_MUL);
   assign w_mul_last   = (r_state == S_MUL) && (r_cnt == CNT_LAST);
   // One multiplier bit per cycle; the final sum is what the result register loads.
   assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_mul) w_state_nxt = S_MUL;
         S_MUL:   if (w_mul_last)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_idle = (r_state == S_IDLE);
      o_busy = (r_state == S_MUL);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)               r_cnt <= '0;
      else if (w_start_mul)         r_cnt <= '0;
      else if (r_state == S_MUL)    r_cnt <= r_cnt + 1'b1;
   end

   // Multiplier operands are data-only and need no reset.
   always_ff @(posedge i_clk) begin
      if (w_start_mul) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_A};
         r_mplier <= i_B;
         r_acc    <= '0;
      end else if (r_state == S_MUL) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end
`else
   assign w_idle       = 1'b1;
   assign o_busy       = 1'b0;
   assign w_accept_alu = w_accept;
`endif

   // ---- stage p1: output register ----
   // A MUL accept only happens with the output empty or transferring, so the
   // final branch correctly clears o_valid on that edge too.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vld_p1    <= 1'b0;
         r_result_p1 <= '0;
         r_status_p1 <= '0;
      end else if (w_accept_alu) begin
         r_vld_p1    <= 1'b1;
         r_result_p1 <= w_alu[WIDTH-1:0];
         r_status_p1 <= w_alu[WIDTH+3:WIDTH];
      end
`ifdef ALU_PIPE_MUL_EN
      else if (w_mul_last) begin
         r_vld_p1    <= 1'b1;
         r_result_p1 <= w_acc_nxt[WIDTH-1:0];
         r_status_p1 <= nzcv(w_acc_nxt[WIDTH-1:0], |w_acc_nxt[2*WIDTH-1:WIDTH], 1'b0);
      end
`endif
      else if (r_vld_p1 && i_ready) begin
         r_vld_p1    <= 1'b0;
      end
   end

   assign o_valid  = r_vld_p1;
   assign o_result = r_result_p1;
   assign o_status = r_status_p1;

endmodule

// File: tb/tb_alu_pipe_nzcv.sv
// Testbench for alu_pipe_nzcv: directed vectors on a WIDTH=4 instance, then
// randomized traffic on WIDTH=4 and WIDTH=8 instances against a reference model.
module tb_alu_pipe_nzcv;

`ifdef ALU_PIPE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       sel;          // 0 selects the WIDTH=4 instance, 1 the WIDTH=8 one
   logic       drv_valid;
   logic       drv_ready;
   logic [7:0] drv_A;
   logic [7:0] drv_B;
   logic [2:0] drv_op;

   logic       rdy4, vld4, busy4;
   logic [3:0] res4, st4;
   logic       rdy8, vld8, busy8;
   logic [7:0] res8;
   logic [3:0] st8;

   logic       obs_ready, obs_valid, obs_busy;
   logic [7:0] obs_result;
   logic [3:0] obs_status;

   int checks = 0;
   int errors = 0;

   alu_pipe_nzcv #(.WIDTH(4)) u_dut4 (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_valid   (drv_valid && !sel),
      .o_ready   (rdy4),
      .i_A       (drv_A[3:0]),
      .i_B       (drv_B[3:0]),
      .i_opcode  (drv_op),
      .o_valid   (vld4),
      .i_ready   (drv_ready || sel),
      .o_result  (res4),
      .o_status  (st4),
      .o_busy    (busy4)
   );

   alu_pipe_nzcv #(.WIDTH(8)) u_dut8 (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_valid   (drv_valid && sel),
      .o_ready   (rdy8),
      .i_A       (drv_A),
      .i_B       (drv_B),
      .i_opcode  (drv_op),
      .o_valid   (vld8),
      .i_ready   (drv_ready || !sel),
      .o_result  (res8),
      .o_status  (st8),
      .o_busy    (busy8)
   );

   assign obs_ready  = sel ? rdy8  : rdy4;
   assign obs_valid  = sel ? vld8  : vld4;
   assign obs_busy   = sel ? busy8 : busy4;
   assign obs_result = sel ? res8  : {4'b0000, res4};
   assign obs_status = sel ? st8   : st4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {N,Z,C,V,result[7:0]} from plain integer arithmetic on w-bit values.
   function automatic logic [11:0] model(input int w, input int op, input int a, input int b);
      int mask, half, sa, sb, r, c, v, t;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      sa   = (a >= half) ? a - (1 << w) : a;
      sb   = (b >= half) ? b - (1 << w) : b;
      r = 0; c = 0; v = 0; t = 0;
      case (op)
         0: begin
            t = a + b;   r = t & mask; c = (t > mask) ? 1 : 0;
            t = sa + sb; v = (t < -half || t >= half) ? 1 : 0;
         end
         1: begin
            r = (a - b) & mask; c = (a >= b) ? 1 : 0;
            t = sa - sb;        v = (t < -half || t >= half) ? 1 : 0;
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (sa < sb) ? 1 : 0;
         6: begin r = (a * 2) & mask; c = (a >= half) ? 1 : 0; end
         default: if (MUL_EN) begin
            t = a * b; r = t & mask; c = ((t >> w) != 0) ? 1 : 0;
         end
      endcase
      return {r >= half, r == 0, c[0], v[0], r[7:0]};
   endfunction

   task automatic single(input string tag, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] eres, input logic [3:0] est);
      @(negedge clk);
      drv_valid = 1'b1; drv_ready = 1'b1; drv_op = op;
      drv_A = {4'b0000, a}; drv_B = {4'b0000, b};
      #1 chk({tag, "_rdy"}, obs_ready, 1);
      @(negedge clk);
      drv_valid = 1'b0; drv_A = 8'hA5; drv_B = 8'h5A;
      #1;
      chk({tag, "_vld"}, obs_valid, 1);
      chk({tag, "_res"}, obs_result, {4'b0000, eres});
      chk({tag, "_st"},  obs_status, est);
   endtask

`ifdef ALU_PIPE_MUL_EN
   task automatic mul_dir(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eres, input logic [3:0] est);
      @(negedge clk);
      drv_valid = 1'b1; drv_ready = 1'b1; drv_op = 3'b111;
      drv_A = {4'b0000, a}; drv_B = {4'b0000, b};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drv_valid = 1'b0;
         drv_A = 8'($urandom_range(0, 255));
         drv_B = 8'($urandom_range(0, 255));
         #1;
         chk({tag, "_busy"},  obs_busy, 1);
         chk({tag, "_novld"}, obs_valid, 0);
         chk({tag, "_nordy"}, obs_ready, 0);
      end
      @(negedge clk);
      #1;
      chk({tag, "_idle"}, obs_busy, 0);
      chk({tag, "_vld"},  obs_valid, 1);
      chk({tag, "_res"},  obs_result, {4'b0000, eres});
      chk({tag, "_st"},   obs_status, est);
   endtask
`endif

   task automatic run_random(input bit wide, input int n_ops);
      int w, accepts, obs_xfers, cycles, m_busy, op, a, b;
      bit m_vld;
      logic exp_rdy;
      logic [11:0] q[$];
      logic [11:0] exp;
      w = wide ? 8 : 4;
      sel = wide;
      accepts = 0; obs_xfers = 0; cycles = 0; m_busy = 0; m_vld = 1'b0;
      while ((accepts < n_ops || m_vld || m_busy != 0) && cycles < 30000) begin
         @(negedge clk);
         cycles++;
         op = $urandom_range(0, 7);
         a  = $urandom_range(0, (1 << w) - 1);
         b  = $urandom_range(0, (1 << w) - 1);
         drv_valid = (accepts < n_ops) && ($urandom_range(0, 9) < 6);
         drv_ready = ($urandom_range(0, 9) < 7);
         drv_op = op[2:0]; drv_A = a[7:0]; drv_B = b[7:0];
         #1;
         exp_rdy = (m_busy == 0) && (!m_vld || drv_ready);
         chk("rnd_ready", obs_ready, exp_rdy);
         chk("rnd_valid", obs_valid, m_vld);
         chk("rnd_busy",  obs_busy, m_busy != 0);
         if (obs_valid && drv_ready) obs_xfers++;
         if (m_vld && drv_ready) begin
            exp = q.pop_front();
            chk("rnd_result", {obs_status, obs_result}, exp);
            m_vld = 1'b0;
         end
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_vld = 1'b1;
         end else if (drv_valid && exp_rdy) begin
            accepts++;
            q.push_back(model(w, op, a, b));
            if (op == 7 && MUL_EN) m_busy = w;
            else                   m_vld = 1'b1;
         end
      end
      drv_valid = 1'b0; drv_ready = 1'b1;
      chk("rnd_accepts", accepts, n_ops);
      chk("rnd_xfers", obs_xfers, n_ops);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sel = 1'b0;
      drv_valid = 1'b0; drv_ready = 1'b1; drv_op = 3'b000; drv_A = 8'h00; drv_B = 8'h00;

      // Reset
      repeat (3) @(negedge clk);
      #1;
      chk("rst_vld",  obs_valid, 0);
      chk("rst_res",  obs_result, 0);
      chk("rst_st",   obs_status, 0);
      chk("rst_busy", obs_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_rdy", obs_ready, 1);

      // ADD vectors
      single("add_7_1",   3'b000, 4'd7,  4'd1,  4'b1000, 4'b1001);
      single("add_m8_m1", 3'b000, 4'b1000, 4'b1111, 4'b0111, 4'b0011);
      single("add_m1_1",  3'b000, 4'b1111, 4'd1, 4'b0000, 4'b0110);
      single("add_4_m4",  3'b000, 4'd4, 4'b1100, 4'b0000, 4'b0110);
      single("add_0_1",   3'b000, 4'd0, 4'd1, 4'b0001, 4'b0000);

      // Other ops
      single("sub_3_5",   3'b001, 4'd3, 4'd5, 4'b1110, 4'b1000);
      single("slt_m2_1",  3'b101, 4'b1110, 4'd1, 4'b0001, 4'b0000);
      single("shl_1001",  3'b110, 4'b1001, 4'd0, 4'b0010, 4'b0010);
      single("xor_c_a",   3'b100, 4'hC, 4'hA, 4'b0110, 4'b0000);

      // Backpressure
      @(negedge clk);
      drv_valid = 1'b1; drv_ready = 1'b0; drv_op = 3'b000; drv_A = 8'd1; drv_B = 8'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drv_valid = 1'b0; drv_A = 8'($urandom_range(0, 255));
         #1;
         chk("bp_vld", obs_valid, 1);
         chk("bp_res", obs_result, 8'h02);
         chk("bp_rdy", obs_ready, 0);
      end
      @(negedge clk);
      drv_valid = 1'b1; drv_ready = 1'b1; drv_op = 3'b000; drv_A = 8'd0; drv_B = 8'd1;
      #1;
      chk("bp_rdy_up", obs_ready, 1);
      chk("bp_hold",   obs_result, 8'h02);
      @(negedge clk);
      drv_valid = 1'b0;
      #1;
      chk("bp_next_vld", obs_valid, 1);
      chk("bp_next_res", obs_result, 8'h01);

`ifdef ALU_PIPE_MUL_EN
      mul_dir("mul_3_5", 4'd3, 4'd5, 4'b1111, 4'b1000);
      mul_dir("mul_5_5", 4'd5, 4'd5, 4'b1001, 4'b1010);
      // Reset during the second multiply cycle aborts it
      @(negedge clk);
      drv_valid = 1'b1; drv_ready = 1'b1; drv_op = 3'b111; drv_A = 8'd3; drv_B = 8'd5;
      @(negedge clk);
      drv_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_vld",  obs_valid, 0);
      chk("mrst_busy", obs_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("mrst_noresult", obs_valid, 0);
         chk("mrst_rdy", obs_ready, 1);
      end
`else
      single("mul_off", 3'b111, 4'd3, 4'd5, 4'b0000, 4'b0100);
      chk("mul_off_busy", obs_busy, 0);
`endif

      // Randomized traffic
      run_random(1'b0, 1000);
      run_random(1'b1, 1000);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
